msi_directory_ctrl: RTL and testbench
=====================================

Name: msi_directory_ctrl

Overview:
- Home-node directory controller for the two-processor (P0,0 / P0,1) MSI directory protocol.
- Sits directly downstream of the test request generator and consumes its per-clock AddressTest/WriteOrRead/Processor/DataTest stream.
- Buffers requests in an input FIFO, keeps per-block directory state plus a 16x4 data array, and issues invalidate/recall messages with an ack handshake.
- Returns one response per request.

Parameters:
- ADDR_W, 4, block address width; the directory holds 2**ADDR_W entries.
- DATA_W, 4, data width.
- FIFO_DEPTH, 16, input FIFO entries; must be a power of 2.

Ports:
- Clock  in  1  rising-edge clock
- Resetn  in  1  asynchronous active-low reset
- ReqValid  in  1  request present this cycle; the generator drives 1 continuously
- AddressTest  in  ADDR_W  block address
- WriteOrRead  in  2  00 read, 01 write, 1x no-op
- Processor  in  2  00 P0,0, 01 P0,1, 1x invalid
- DataTest  in  DATA_W  write data
- Overflow  out  1  sticky: a request was dropped because the FIFO was full
- InvValid  out  1  coherence message pending
- InvType  out  1  0 invalidate, 1 recall (M->S downgrade)
- InvProcessor  out  1  target processor
- InvAddress  out  ADDR_W  target block
- InvAck  in  1  target acknowledges; sampled on the clock edge
- RspValid  out  1  one-cycle response pulse
- RspProcessor  out  1  requester
- RspAddress  out  ADDR_W  block
- RspData  out  DATA_W  read: array value; write: written data
- RspHit  out  1  requester already held sufficient permission
- RspState  out  2  resulting directory state: 00 U, 01 S, 10 M

Behaviour:
- Reset (async, Resetn=0):
  - FIFO empty; FSM goes to IDLE.
  - All directory entries become U, sharers=00, owner=0; data array cleared to 0.
  - All outputs 0, including Overflow.
  - Reset during any state aborts the transaction with no response.
- Enqueue:
  - Push on each edge with ReqValid=1, Processor[1]=0 and WriteOrRead[1]=0.
  - Requests with Processor[1]=1 or WriteOrRead[1]=1 are silently discarded and do not set Overflow.
  - If the FIFO is full, the request is dropped and Overflow is set (sticky until reset).
  - A pop and a push on the same edge are both honoured while full.
- FSM states: IDLE, LOOKUP, INVAL, UPDATE, RESPOND.
  - IDLE: if the FIFO is not empty, pop the head into the transaction register -> LOOKUP.
  - LOOKUP: read the directory entry and compute the action per the table below.
    - Nothing pending -> UPDATE.
    - Otherwise load the target list -> INVAL.
  - INVAL: hold InvValid, InvType, InvProcessor and InvAddress stable until an edge with InvAck=1. Then take the next target, or go to UPDATE. There is no timeout.
  - UPDATE: write the directory entry; a write also stores DataTest in the array -> RESPOND.
  - RESPOND: RspValid=1 for exactly one cycle -> IDLE.
- Protocol (requester r, other processor o):
  - Read, U: no message; S with sharers={r}; RspHit=0.
  - Read, S: no message; add r to sharers; RspHit=1 if r was already a sharer.
  - Read, M owned by r: no message; RspHit=1.
  - Read, M owned by o: recall o; S with sharers={o,r}; RspHit=0.
  - Write, U: no message; M owned by r; RspHit=0.
  - Write, S: invalidate every sharer other than r; M owned by r; RspHit=0.
  - Write, M owned by r: no message; RspHit=1.
  - Write, M owned by o: invalidate o; M owned by r; RspHit=0.
- Data array: writes update the array at UPDATE (functional model). Read data is the array value after UPDATE.
- Latency:
  - Push at edge N with the FIFO empty and FSM in IDLE: pop at N+1, LOOKUP->UPDATE at N+2, RspValid high after edge N+3.
  - Each target adds ack wait + 1 cycle.
  - Minimum 4 cycles per request.
- A request to the same address as the in-flight one waits in the FIFO; strict in-order processing, no bypass.

Decomposition:
- Shared package msi_pkg holds:
  - directory state encoding (U/S/M), op encoding, processor IDs;
  - InvType encoding and the FSM state typedef;
  - a directory entry struct {state, sharers[1:0], owner}.
- One sub-module: msi_req_fifo, a parameterised synchronous FIFO with full/empty flags and async active-low reset.

Test Plan:
- Run the nine-request generator sequence with InvAck asserted one cycle after InvValid. Required RspData/RspHit/RspState:
  1. P0 read 1 -> 0/0/S
  2. P0 read 6 -> 0/0/S
  3. P0 write 6<-7 -> 7/0/M, no InvValid
  4. P0 read 5 -> 0/0/S
  5. P1 read 5 -> 0/0/S
  6. P1 write 5<-8 -> invalidate P0 addr 5, then 8/0/M
  7. P0 write 5<-9 -> invalidate P1, then 9/0/M
  8. P1 read 5 -> recall P0, then 9/0/S
  9. P1 read 1 -> 0/0/S
- Overflow: FIFO_DEPTH=4, eight back-to-back requests, InvAck never asserted -> Overflow=1, and only the accepted requests eventually respond once InvAck is re-enabled.
- Handshake hold: keep InvAck=0 for 10 cycles during step 6 -> InvValid/InvAddress=5/InvProcessor=0 stay stable and no RspValid appears.
- Filter: Processor=2'b10 or WriteOrRead=2'b11 -> no push, no response, Overflow stays 0.
- Reset mid-INVAL: drop Resetn while InvValid=1 -> all outputs 0 immediately; afterwards P1 read 5 -> 0/0/S (directory cleared).
- Repeat hit: P0 read 1 twice -> second response has RspHit=1, state S, sharers unchanged.

Source files
------------

// File: rtl/msi_pkg.sv
// rtl/msi_pkg.sv - shared encodings and types for the MSI directory controller
//
// Purpose: directory state, op, processor and coherence-message encodings,
//          FSM state type and the per-block directory entry.
// Ports:   none (package).

package msi_pkg;

    typedef enum logic [1:0] {
        DIR_U = 2'b00,
        DIR_S = 2'b01,
        DIR_M = 2'b10
    } dir_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam logic PROC_0 = 1'b0;
    localparam logic PROC_1 = 1'b1;

    typedef enum logic {
        INV_INVALIDATE = 1'b0,
        INV_RECALL     = 1'b1
    } inv_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_INVAL,
        ST_UPDATE,
        ST_RESPOND
    } fsm_state_t;

    // sharers[n] is set when processor n holds a copy
    typedef struct packed {
        dir_state_t state;
        logic [1:0] sharers;
        logic       owner;
    } dir_entry_t;

    localparam dir_entry_t DIR_ENTRY_RESET = '{state: DIR_U, sharers: 2'b00, owner: PROC_0};

    function automatic logic [1:0] proc_bit(input logic p);
        return (p == PROC_1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/msi_req_fifo.sv
// rtl/msi_req_fifo.sv - synchronous request FIFO with full/empty flags
//
// Purpose: buffers request words between the generator and the directory FSM.
// Ports:   Clock, Resetn (async active-low); push/wdata write side;
//          pop/rdata read side (rdata shows the head combinationally);
//          full, empty status.
// A push while full is ignored unless a pop happens on the same edge.

module msi_req_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == DEPTH[PW:0]);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/msi_directory_ctrl.sv
// rtl/msi_directory_ctrl.sv - two-processor MSI home-node directory controller
//
// Purpose: queues requests, looks up the directory, sends invalidate/recall
//          messages with ack handshake, updates directory/data, responds.
// Ports:   Clock, Resetn (async active-low);
//          ReqValid/AddressTest/WriteOrRead/Processor/DataTest request input;
//          Overflow sticky drop flag;
//          InvValid/InvType/InvProcessor/InvAddress message out, InvAck in;
//          RspValid/RspProcessor/RspAddress/RspData/RspHit/RspState response.

module msi_directory_ctrl
    import msi_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              ReqValid,
    input  logic [ADDR_W-1:0] AddressTest,
    input  logic [1:0]        WriteOrRead,
    input  logic [1:0]        Processor,
    input  logic [DATA_W-1:0] DataTest,
    output logic              Overflow,
    output logic              InvValid,
    output logic              InvType,
    output logic              InvProcessor,
    output logic [ADDR_W-1:0] InvAddress,
    input  logic              InvAck,
    output logic              RspValid,
    output logic              RspProcessor,
    output logic [ADDR_W-1:0] RspAddress,
    output logic [DATA_W-1:0] RspData,
    output logic              RspHit,
    output logic [1:0]        RspState
);

    localparam int DIR_N = 1 << ADDR_W;
    localparam int REQ_W = ADDR_W + DATA_W + 2;

    logic              req_ok;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [REQ_W-1:0]  fifo_rdata;

    fsm_state_t        state;
    logic [ADDR_W-1:0] txn_addr;
    logic              txn_op;
    logic              txn_proc;
    logic [DATA_W-1:0] txn_data;

    dir_entry_t        dir [DIR_N];
    logic [DATA_W-1:0] data_mem [DIR_N];

    dir_entry_t        cur_entry;
    dir_entry_t        nxt_entry;
    dir_entry_t        nxt_q;
    logic              lk_hit;
    logic              hit_q;
    logic [1:0]        lk_targets;
    logic [1:0]        targets_q;
    logic              lk_type;
    logic [1:0]        rbit;
    logic [1:0]        obit;

    // No-ops and invalid processor IDs never reach the FIFO
    assign req_ok   = ReqValid && !Processor[1] && !WriteOrRead[1];
    assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

    msi_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock  (Clock),
        .Resetn (Resetn),
        .push   (req_ok),
        .wdata  ({AddressTest, WriteOrRead[0], Processor[0], DataTest}),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Protocol table: next entry, hit flag and processors needing a message
    always_comb begin
        cur_entry  = dir[txn_addr];
        nxt_entry  = cur_entry;
        lk_hit     = 1'b0;
        lk_targets = 2'b00;
        lk_type    = INV_INVALIDATE;
        rbit       = proc_bit(txn_proc);
        obit       = proc_bit(!txn_proc);
        if (txn_op == OP_READ) begin
            case (cur_entry.state)
                DIR_U: begin
                    nxt_entry.state   = DIR_S;
                    nxt_entry.sharers = rbit;
                end
                DIR_S: begin
                    lk_hit            = |(cur_entry.sharers & rbit);
                    nxt_entry.sharers = cur_entry.sharers | rbit;
                end
                DIR_M: begin
                    if (cur_entry.owner == txn_proc) begin
                        lk_hit = 1'b1;
                    end else begin
                        lk_targets        = obit;
                        lk_type           = INV_RECALL;
                        nxt_entry.state   = DIR_S;
                        nxt_entry.sharers = 2'b11;
                    end
                end
                default: ;
            endcase
        end else begin
            nxt_entry = '{state: DIR_M, sharers: rbit, owner: txn_proc};
            if (cur_entry.state == DIR_S)
                lk_targets = cur_entry.sharers & ~rbit;
            else if (cur_entry.state == DIR_M && cur_entry.owner != txn_proc)
                lk_targets = obit;
            lk_hit = (cur_entry.state == DIR_M) && (cur_entry.owner == txn_proc);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state        <= ST_IDLE;
            txn_addr     <= '0;
            txn_op       <= 1'b0;
            txn_proc     <= 1'b0;
            txn_data     <= '0;
            nxt_q        <= DIR_ENTRY_RESET;
            hit_q        <= 1'b0;
            targets_q    <= 2'b00;
            Overflow     <= 1'b0;
            InvValid     <= 1'b0;
            InvType      <= 1'b0;
            InvProcessor <= 1'b0;
            InvAddress   <= '0;
            RspValid     <= 1'b0;
            RspProcessor <= 1'b0;
            RspAddress   <= '0;
            RspData      <= '0;
            RspHit       <= 1'b0;
            RspState     <= 2'b00;
            for (int i = 0; i < DIR_N; i++) begin
                dir[i]      <= DIR_ENTRY_RESET;
                data_mem[i] <= '0;
            end
        end else begin
            if (req_ok && fifo_full && !fifo_pop) Overflow <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {txn_addr, txn_op, txn_proc, txn_data} <= fifo_rdata;
                        state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    nxt_q <= nxt_entry;
                    hit_q <= lk_hit;
                    if (lk_targets == 2'b00) begin
                        state <= ST_UPDATE;
                    end else begin
                        // Serve P0 first; whatever remains waits in targets_q
                        InvValid     <= 1'b1;
                        InvType      <= lk_type;
                        InvProcessor <= !lk_targets[0];
                        InvAddress   <= txn_addr;
                        targets_q    <= lk_targets & (lk_targets[0] ? 2'b10 : 2'b00);
                        state        <= ST_INVAL;
                    end
                end
                ST_INVAL: begin
                    if (InvAck) begin
                        if (targets_q != 2'b00) begin
                            InvProcessor <= !targets_q[0];
                            targets_q    <= targets_q & (targets_q[0] ? 2'b10 : 2'b00);
                        end else begin
                            InvValid <= 1'b0;
                            state    <= ST_UPDATE;
                        end
                    end
                end
                ST_UPDATE: begin
                    dir[txn_addr] <= nxt_q;
                    if (txn_op == OP_WRITE) data_mem[txn_addr] <= txn_data;
                    RspValid     <= 1'b1;
                    RspProcessor <= txn_proc;
                    RspAddress   <= txn_addr;
                    RspData      <= (txn_op == OP_WRITE) ? txn_data : data_mem[txn_addr];
                    RspHit       <= hit_q;
                    RspState     <= nxt_q.state;
                    state        <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    RspValid <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msi_directory_ctrl.sv
// tb/tb_msi_directory_ctrl.sv - directed self-checking bench for msi_directory_ctrl

module tb_msi_directory_ctrl;

    localparam logic [1:0] RD   = 2'b00;
    localparam logic [1:0] WR   = 2'b01;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    typedef struct {
        logic       proc;
        logic [3:0] addr;
        logic [3:0] data;
        logic       hit;
        logic [1:0] st;
    } rsp_t;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       ReqValid = 1'b0;
    logic [3:0] AddressTest = '0;
    logic [1:0] WriteOrRead = '0;
    logic [1:0] Processor = '0;
    logic [3:0] DataTest = '0;
    logic       Overflow;
    logic       InvValid;
    logic       InvType;
    logic       InvProcessor;
    logic [3:0] InvAddress;
    logic       InvAck = 1'b0;
    logic       RspValid;
    logic       RspProcessor;
    logic [3:0] RspAddress;
    logic [3:0] RspData;
    logic       RspHit;
    logic [1:0] RspState;

    int   n_checks = 0;
    int   n_errors = 0;
    rsp_t rsp_q[$];
    int   inv_cnt = 0;
    logic inv_prev = 1'b0;
    logic last_inv_proc = 1'b0;
    logic last_inv_type = 1'b0;
    logic [3:0] last_inv_addr = '0;
    logic auto_ack = 1'b1;

    msi_directory_ctrl #(
        .ADDR_W     (4),
        .DATA_W     (4),
        .FIFO_DEPTH (4)
    ) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .ReqValid     (ReqValid),
        .AddressTest  (AddressTest),
        .WriteOrRead  (WriteOrRead),
        .Processor    (Processor),
        .DataTest     (DataTest),
        .Overflow     (Overflow),
        .InvValid     (InvValid),
        .InvType      (InvType),
        .InvProcessor (InvProcessor),
        .InvAddress   (InvAddress),
        .InvAck       (InvAck),
        .RspValid     (RspValid),
        .RspProcessor (RspProcessor),
        .RspAddress   (RspAddress),
        .RspData      (RspData),
        .RspHit       (RspHit),
        .RspState     (RspState)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        InvAck = auto_ack && InvValid && !InvAck;
    end

    always @(negedge Clock) begin
        if (RspValid)
            rsp_q.push_back('{RspProcessor, RspAddress, RspData, RspHit, RspState});
        if (InvValid && !inv_prev) begin
            inv_cnt++;
            last_inv_proc = InvProcessor;
            last_inv_type = InvType;
            last_inv_addr = InvAddress;
        end
        inv_prev = InvValid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge Clock);
        Resetn = 1'b0;
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        rsp_q.delete();
        inv_cnt = 0;
    endtask

    task automatic drive(input logic [1:0] p, input logic [1:0] wr, input logic [3:0] a, input logic [3:0] d);
        @(negedge Clock);
        ReqValid    = 1'b1;
        Processor   = p;
        WriteOrRead = wr;
        AddressTest = a;
        DataTest    = d;
    endtask

    task automatic send(input logic [1:0] p, input logic [1:0] wr, input logic [3:0] a, input logic [3:0] d);
        drive(p, wr, a, d);
        @(negedge Clock);
        ReqValid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic p, input logic [3:0] a,
                              input logic [3:0] d, input logic h, input logic [1:0] st);
        int   n = 0;
        rsp_t r;
        while (rsp_q.size() == 0 && n < 60) begin
            @(negedge Clock);
            n++;
        end
        if (rsp_q.size() == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            r = rsp_q.pop_front();
            check({tag, "_proc"}, r.proc, p);
            check({tag, "_addr"}, r.addr, a);
            check({tag, "_data"}, r.data, d);
            check({tag, "_hit"}, r.hit, h);
            check({tag, "_state"}, r.st, st);
        end
    endtask

    task automatic step(input string tag, input logic [1:0] p, input logic [1:0] wr,
                        input logic [3:0] a, input logic [3:0] d, input logic [3:0] exp_d,
                        input logic exp_h, input logic [1:0] exp_st, input int exp_inv,
                        input logic exp_inv_proc, input logic exp_inv_type);
        inv_cnt = 0;
        send(p, wr, a, d);
        expect_rsp(tag, p[0], a, exp_d, exp_h, exp_st);
        check({tag, "_inv_cnt"}, inv_cnt, exp_inv);
        if (exp_inv > 0) begin
            check({tag, "_inv_proc"}, last_inv_proc, exp_inv_proc);
            check({tag, "_inv_type"}, last_inv_type, exp_inv_type);
            check({tag, "_inv_addr"}, last_inv_addr, a);
        end
    endtask

    task automatic wait_inv(input string tag);
        int n = 0;
        while (!InvValid && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check({tag, "_inv_seen"}, InvValid, 1'b1);
    endtask

    function automatic logic [20:0] all_outputs();
        return {Overflow, InvValid, InvType, InvProcessor, InvAddress, RspValid,
                RspProcessor, RspAddress, RspData, RspHit, RspState};
    endfunction

    initial begin
        repeat (2) @(negedge Clock);
        check("reset_outputs", all_outputs(), 21'd0);
        Resetn = 1'b1;
        rsp_q.delete();

        // Generator sequence
        step("s1", 2'd0, RD, 4'd1, 4'd0, 4'd0, 1'b0, ST_S, 0, 1'b0, 1'b0);
        step("s2", 2'd0, RD, 4'd6, 4'd0, 4'd0, 1'b0, ST_S, 0, 1'b0, 1'b0);
        step("s3", 2'd0, WR, 4'd6, 4'd7, 4'd7, 1'b0, ST_M, 0, 1'b0, 1'b0);
        step("s4", 2'd0, RD, 4'd5, 4'd0, 4'd0, 1'b0, ST_S, 0, 1'b0, 1'b0);
        step("s5", 2'd1, RD, 4'd5, 4'd0, 4'd0, 1'b0, ST_S, 0, 1'b0, 1'b0);

        // Step 6 with the ack held off for 10 cycles
        auto_ack = 1'b0;
        inv_cnt  = 0;
        send(2'd1, WR, 4'd5, 4'd8);
        wait_inv("s6");
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            check("s6_hold_valid", InvValid, 1'b1);
            check("s6_hold_addr", InvAddress, 4'd5);
            check("s6_hold_proc", InvProcessor, 1'b0);
            check("s6_hold_type", InvType, 1'b0);
            check("s6_hold_no_rsp", RspValid, 1'b0);
        end
        auto_ack = 1'b1;
        expect_rsp("s6", 1'b1, 4'd5, 4'd8, 1'b0, ST_M);
        check("s6_inv_cnt", inv_cnt, 1);

        step("s7", 2'd0, WR, 4'd5, 4'd9, 4'd9, 1'b0, ST_M, 1, 1'b1, 1'b0);
        step("s8", 2'd1, RD, 4'd5, 4'd0, 4'd9, 1'b0, ST_S, 1, 1'b0, 1'b1);
        step("s9", 2'd1, RD, 4'd1, 4'd0, 4'd0, 1'b0, ST_S, 0, 1'b0, 1'b0);

        // Filtered requests: invalid processor and no-op
        send(2'b10, RD, 4'd3, 4'd0);
        send(2'b00, 2'b11, 4'd3, 4'd0);
        repeat (10) @(negedge Clock);
        check("filter_no_rsp", rsp_q.size(), 0);
        check("filter_no_overflow", Overflow, 1'b0);

        // Reset while an invalidate is outstanding
        auto_ack = 1'b0;
        send(2'd1, WR, 4'd5, 4'd6);
        wait_inv("rst_mid");
        Resetn = 1'b0;
        #1;
        check("rst_mid_outputs", all_outputs(), 21'd0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        auto_ack = 1'b1;
        rsp_q.delete();
        repeat (10) @(negedge Clock);
        check("rst_mid_no_rsp", rsp_q.size(), 0);
        step("rst_p1_rd5", 2'd1, RD, 4'd5, 4'd0, 4'd0, 1'b0, ST_S, 0, 1'b0, 1'b0);

        // Repeat hit; P1 afterwards shows the sharers were not widened
        step("rep1", 2'd0, RD, 4'd1, 4'd0, 4'd0, 1'b0, ST_S, 0, 1'b0, 1'b0);
        step("rep2", 2'd0, RD, 4'd1, 4'd0, 4'd0, 1'b1, ST_S, 0, 1'b0, 1'b0);
        step("rep3", 2'd1, RD, 4'd1, 4'd0, 4'd0, 1'b0, ST_S, 0, 1'b0, 1'b0);

        // Overflow: block 5 owned by P0, then a burst stalls behind a recall
        apply_reset();
        step("ov_setup", 2'd0, WR, 4'd5, 4'd3, 4'd3, 1'b0, ST_M, 0, 1'b0, 1'b0);
        auto_ack = 1'b0;
        drive(2'd1, RD, 4'd5, 4'd0);
        drive(2'd0, RD, 4'd2, 4'd0);
        drive(2'd1, RD, 4'd2, 4'd0);
        drive(2'd1, RD, 4'd2, 4'd0);
        drive(2'd0, WR, 4'd3, 4'd4);
        drive(2'd1, WR, 4'd9, 4'd1);
        drive(2'd0, RD, 4'd10, 4'd0);
        drive(2'd1, RD, 4'd11, 4'd0);
        @(negedge Clock);
        ReqValid = 1'b0;
        repeat (5) @(negedge Clock);
        check("ov_flag", Overflow, 1'b1);
        check("ov_stalled_no_rsp", rsp_q.size(), 0);
        auto_ack = 1'b1;
        expect_rsp("ov_r1", 1'b1, 4'd5, 4'd3, 1'b0, ST_S);
        expect_rsp("ov_r2", 1'b0, 4'd2, 4'd0, 1'b0, ST_S);
        expect_rsp("ov_r3", 1'b1, 4'd2, 4'd0, 1'b0, ST_S);
        expect_rsp("ov_r4", 1'b1, 4'd2, 4'd0, 1'b1, ST_S);
        expect_rsp("ov_r5", 1'b0, 4'd3, 4'd4, 1'b0, ST_M);
        repeat (30) @(negedge Clock);
        check("ov_no_extra_rsp", rsp_q.size(), 0);
        check("ov_flag_sticky", Overflow, 1'b1);
        step("ov_dropped_wr9", 2'd0, RD, 4'd9, 4'd0, 4'd0, 1'b0, ST_S, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
